// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/func encodings, FSM states and zon flag indices for mips_alu_seq
package alu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } alu_state_e;

   localparam int ZON_ZERO = 2;
   localparam int ZON_OVF  = 1;
   localparam int ZON_NEG  = 0;

   // Two's-complement add overflow from sign bits; subtraction passes ~b_msb.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiply / restoring divide with sign fixup
// ALU_FAST_MULT_EN: multiply finishes in one BUSY cycle with a combinational multiplier.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             is_div_i,
   input  logic             is_signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             dbz_o
);

   localparam int CNT_W = $clog2(WIDTH);

   logic               run_q, div_q, sa_q, sb_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   a_raw_q, b_mag_q;
   logic [2*WIDTH-1:0] work_q, work_d;

   logic               a_neg, b_neg, last;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
   logic [WIDTH:0]     rem_sh, diff;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign a_neg = is_signed_i & a_i[WIDTH-1];
   assign b_neg = is_signed_i & b_i[WIDTH-1];
   assign a_mag = a_neg ? -a_i : a_i;
   assign b_mag = b_neg ? -b_i : b_i;

   // work_q low half starts as multiplier / dividend; high half accumulates product / remainder.
`ifdef ALU_FAST_MULT_EN
   assign mul_step = {{WIDTH{1'b0}}, work_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, b_mag_q};
   assign last     = div_q ? (cnt_q == CNT_W'(WIDTH-1)) : 1'b1;
`else
   logic [WIDTH:0] mul_sum;
   assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, b_mag_q} : '0);
   assign mul_step = {mul_sum, work_q[WIDTH-1:1]};
   assign last     = (cnt_q == CNT_W'(WIDTH-1));
`endif

   assign rem_sh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   assign diff     = rem_sh - {1'b0, b_mag_q};
   assign div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0],   work_q[WIDTH-2:0], 1'b1};
   assign work_d   = div_q ? div_step : mul_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         a_raw_q <= '0;
         b_mag_q <= '0;
         work_q  <= '0;
      end else if (start_i) begin
         run_q   <= 1'b1;
         cnt_q   <= '0;
         div_q   <= is_div_i;
         sa_q    <= a_neg;
         sb_q    <= b_neg;
         a_raw_q <= a_i;
         b_mag_q <= b_mag;
         work_q  <= {{WIDTH{1'b0}}, a_mag};
      end else if (run_q) begin
         work_q <= work_d;
         if (last) begin
            run_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign done_o   = run_q & last;
   assign prod_fix = (sa_q ^ sb_q) ? -work_q : work_q;
   assign quo_fix  = (sa_q ^ sb_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
   assign rem_fix  = sa_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
   assign dbz_o    = div_q & (b_mag_q == '0);

   always_comb begin
      hi_o = prod_fix[2*WIDTH-1:WIDTH];
      lo_o = prod_fix[WIDTH-1:0];
      if (div_q) begin
         if (dbz_o) begin
            hi_o = a_raw_q;
            lo_o = '1;
         end else begin
            hi_o = rem_fix;
            lo_o = quo_fix;
         end
      end
   end

endmodule

// File: rtl/mips_alu_seq.sv
// rtl/mips_alu_seq.sv - sequential MIPS ALU: single-cycle simple ops, multi-cycle mult/div into HI/LO
module mips_alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      i_datain,
   input  logic [WIDTH-1:0] gr1,
   input  logic [WIDTH-1:0] gr2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic [2:0]       zon,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int MSB = WIDTH - 1;

   alu_state_e       state_q, state_d;
   logic             ready_q;
   logic [WIDTH-1:0] c_q, c_d, hi_q, hi_d, lo_q, lo_d;
   logic [2:0]       zon_q, zon_d;
   logic             dbz_q, dbz_d;

   logic [5:0]       opcode, func;
   logic [WIDTH-1:0] imm_sx, imm_zx, imm_lui, add_rr, sub_rr, add_ri;
   int unsigned      sh_imm, sh_var;
   logic             accept, md_start, md_op, md_div, md_signed;
   logic             md_done, md_dbz;
   logic [WIDTH-1:0] md_hi, md_lo, alu_res;
   logic             alu_ovf;
   logic             unused_fields;

   assign opcode  = i_datain[31:26];
   assign func    = i_datain[5:0];
   assign imm_sx  = WIDTH'($signed(i_datain[15:0]));
   assign imm_zx  = WIDTH'(i_datain[15:0]);
   assign imm_lui = WIDTH'({i_datain[15:0], 16'h0000});
   assign sh_imm  = 32'(i_datain[10:6]) % unsigned'(WIDTH);
   assign sh_var  = 32'(gr2[SHAMT_W-1:0]) % unsigned'(WIDTH);
   assign add_rr  = gr1 + gr2;
   assign sub_rr  = gr1 - gr2;
   assign add_ri  = gr1 + imm_sx;
   assign unused_fields = ^i_datain[25:16];

   function automatic logic [2:0] mk_zon(input logic [WIDTH-1:0] r, input logic ovf);
      logic [2:0] z;
      z[ZON_ZERO] = (r == '0);
      z[ZON_OVF]  = ovf;
      z[ZON_NEG]  = r[WIDTH-1];
      return z;
   endfunction

   always_comb begin
      alu_res   = '0;
      alu_ovf   = 1'b0;
      md_op     = 1'b0;
      md_div    = 1'b0;
      md_signed = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (func)
               FN_ADD:   begin alu_res = add_rr; alu_ovf = add_ovf(gr1[MSB], gr2[MSB], add_rr[MSB]); end
               FN_ADDU:  alu_res = add_rr;
               FN_SUB:   begin alu_res = sub_rr; alu_ovf = add_ovf(gr1[MSB], ~gr2[MSB], sub_rr[MSB]); end
               FN_SUBU:  alu_res = sub_rr;
               FN_AND:   alu_res = gr1 & gr2;
               FN_OR:    alu_res = gr1 | gr2;
               FN_XOR:   alu_res = gr1 ^ gr2;
               FN_NOR:   alu_res = ~(gr1 | gr2);
               FN_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(gr1) < $signed(gr2)};
               FN_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, gr1 < gr2};
               FN_SLL:   alu_res = gr1 << sh_imm;
               FN_SRL:   alu_res = gr1 >> sh_imm;
               FN_SRA:   alu_res = $unsigned($signed(gr1) >>> sh_imm);
               FN_SLLV:  alu_res = gr1 << sh_var;
               FN_SRLV:  alu_res = gr1 >> sh_var;
               FN_SRAV:  alu_res = $unsigned($signed(gr1) >>> sh_var);
               FN_MFHI:  alu_res = hi_q;
               FN_MFLO:  alu_res = lo_q;
               FN_MULT:  begin md_op = 1'b1; md_signed = 1'b1; end
               FN_MULTU: md_op = 1'b1;
               FN_DIV:   begin md_op = 1'b1; md_div = 1'b1; md_signed = 1'b1; end
               FN_DIVU:  begin md_op = 1'b1; md_div = 1'b1; end
               default:  alu_res = '0;
            endcase
         end
         OP_ADDI:  begin alu_res = add_ri; alu_ovf = add_ovf(gr1[MSB], imm_sx[MSB], add_ri[MSB]); end
         OP_ADDIU: alu_res = add_ri;
         OP_SLTI:  alu_res = {{(WIDTH-1){1'b0}}, $signed(gr1) < $signed(imm_sx)};
         OP_SLTIU: alu_res = {{(WIDTH-1){1'b0}}, gr1 < imm_sx};
         OP_ANDI:  alu_res = gr1 & imm_zx;
         OP_ORI:   alu_res = gr1 | imm_zx;
         OP_XORI:  alu_res = gr1 ^ imm_zx;
         OP_LUI:   alu_res = imm_lui;
         default:  alu_res = '0;
      endcase
   end

   // ready_q keeps in_ready low through reset and until the first edge after release.
   assign in_ready = ready_q & (state_q == IDLE);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d  = state_q;
      c_d      = c_q;
      zon_d    = zon_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = dbz_q;
      md_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (md_op) begin
                  md_start = 1'b1;
                  state_d  = BUSY;
               end else begin
                  c_d     = alu_res;
                  zon_d   = mk_zon(alu_res, alu_ovf);
                  dbz_d   = 1'b0;
                  state_d = DONE;
               end
            end
         end
         BUSY: begin
            if (md_done) state_d = FIX;
         end
         FIX: begin
            hi_d    = md_hi;
            lo_d    = md_lo;
            c_d     = md_lo;
            zon_d   = mk_zon(md_lo, 1'b0);
            dbz_d   = md_dbz;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         c_q     <= '0;
         zon_q   <= 3'b000;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= 1'b1;
         c_q     <= c_d;
         zon_q   <= zon_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   alu_muldiv_iter #(
      .WIDTH(WIDTH)
   ) u_muldiv (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (md_start),
      .is_div_i   (md_div),
      .is_signed_i(md_signed),
      .a_i        (gr1),
      .b_i        (gr2),
      .done_o     (md_done),
      .hi_o       (md_hi),
      .lo_o       (md_lo),
      .dbz_o      (md_dbz)
   );

   assign out_valid   = (state_q == DONE);
   assign c           = c_q;
   assign zon         = zon_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_alu_seq.sv
// tb/tb_mips_alu_seq.sv - directed self-checking bench for mips_alu_seq
module tb_mips_alu_seq;

   localparam int W = 32;
`ifdef ALU_FAST_MULT_EN
   localparam int MUL_LAT = 3;
`else
   localparam int MUL_LAT = W + 2;
`endif
   localparam int DIV_LAT = W + 2;

   localparam logic [31:0] I_ADD   = 32'h0000_0020;
   localparam logic [31:0] I_SUB   = 32'h0000_0022;
   localparam logic [31:0] I_SLT   = 32'h0000_002A;
   localparam logic [31:0] I_SLTU  = 32'h0000_002B;
   localparam logic [31:0] I_SLL1  = 32'h0001_1040;
   localparam logic [31:0] I_SRA4  = 32'h0000_0103;
   localparam logic [31:0] I_MFHI  = 32'h0000_0010;
   localparam logic [31:0] I_MULT  = 32'h0000_0018;
   localparam logic [31:0] I_MULTU = 32'h0000_0019;
   localparam logic [31:0] I_DIV   = 32'h0000_001A;
   localparam logic [31:0] I_DIVU  = 32'h0000_001B;
   localparam logic [31:0] I_BAD   = 32'hFC00_0000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [31:0]  i_datain = '0;
   logic [W-1:0] gr1 = '0, gr2 = '0;
   logic         in_ready, out_valid, div_by_zero;
   logic [W-1:0] c, hi, lo;
   logic [2:0]   zon;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mips_alu_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .i_datain   (i_datain),
      .gr1        (gr1),
      .gr2        (gr2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .c          (c),
      .zon        (zon),
      .hi         (hi),
      .lo         (lo),
      .div_by_zero(div_by_zero)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [31:0] ins, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_issue", in_ready, 1);
      i_datain = ins;
      gr1      = a;
      gr2      = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 200);
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [31:0] ins, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_c,
                         input logic [2:0] exp_zon, input int exp_lat);
      int lat;
      start_op(ins, a, b);
      wait_result(lat);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_c"}, c, exp_c);
      check({tag, "_zon"}, zon, exp_zon);
      consume();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seen;

      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_c", c, 0);
      check("rst_zon", zon, 3'b000);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_dbz", div_by_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);

      // add with result held under backpressure
      start_op(I_ADD, 32'hC040_4040, 32'hFFFF_FFFF);
      wait_result(lat);
      check("add_latency", lat, 1);
      check("add_c", c, 32'hC040_403F);
      check("add_zon", zon, 3'b001);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_c_stable", c, 32'hC040_403F);
         check("bp_in_ready_low", in_ready, 0);
         check("bp_out_valid_high", out_valid, 1);
      end
      consume();

      run_op("sll",       I_SLL1, 32'hDDDD_DDDD, 32'h0,          32'hBBBB_BBBA, 3'b001, 1);
      run_op("addi",      32'h2000_00D0, 32'h1,  32'h0,          32'h0000_00D1, 3'b000, 1);
      run_op("addi_ovf",  32'h2000_0001, 32'h7FFF_FFFF, 32'h0,   32'h8000_0000, 3'b011, 1);
      run_op("sub_ovf",   I_SUB,  32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 3'b010, 1);
      run_op("slt",       I_SLT,  32'hFFFF_FFFF, 32'h1,          32'h1,         3'b000, 1);
      run_op("sltu",      I_SLTU, 32'hFFFF_FFFF, 32'h1,          32'h0,         3'b100, 1);
      run_op("sra",       I_SRA4, 32'h8000_0000, 32'h0,          32'hF800_0000, 3'b001, 1);
      run_op("lui",       32'h3C00_1234, 32'h0,  32'h0,          32'h1234_0000, 3'b000, 1);

      run_op("mult",      I_MULT, 32'hFFFF_FFFD, 32'h5,          32'hFFFF_FFF1, 3'b001, MUL_LAT);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFF1);
      check("mult_dbz", div_by_zero, 0);
      run_op("mfhi",      I_MFHI, 32'h0,         32'h0,          32'hFFFF_FFFF, 3'b001, 1);
      check("mfhi_hi_kept", hi, 32'hFFFF_FFFF);

      run_op("div",       I_DIV,  32'h7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 3'b001, DIV_LAT);
      check("div_hi", hi, 32'h1);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_dbz", div_by_zero, 0);

      start_op(I_DIV, 32'h7, 32'h0);
      wait_result(lat);
      check("div0_latency", lat, DIV_LAT);
      check("div0_hi", hi, 32'h7);
      check("div0_lo", lo, 32'hFFFF_FFFF);
      check("div0_dbz", div_by_zero, 1);
      consume();

      run_op("bad_op",    I_BAD,  32'h1234_5678, 32'h1,          32'h0,         3'b100, 1);
      check("bad_hi_kept", hi, 32'h7);
      check("bad_lo_kept", lo, 32'hFFFF_FFFF);
      check("bad_dbz_clear", div_by_zero, 0);

      run_op("multu",     I_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000, MUL_LAT);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      run_op("divu",      I_DIVU, 32'd100,       32'd7,          32'd14,        3'b000, DIV_LAT);
      check("divu_hi", hi, 32'd2);

      // reset in the middle of a divide
      start_op(I_DIVU, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      check("midrst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_ready_after", in_ready, 1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst_no_result", seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
